spi_slave_ram_param: RTL
========================

// Module: spi_slave_ram_param
// PURPOSE
//  SPI slave with an integrated single-port RAM; successor of the fixed 8-bit slave+RAM wrapper.
//  Address and data widths, RAM depth and address auto-increment are parameters.
//  Out-of-range addresses are detected, and aborted or bad frames are flagged.
//  Sits between an off-chip SPI master (synchronous to clk) and an on-chip register/data store.
// PARAMETERS
//  ADDR_WIDTH  8    RAM address width in bits.
//  DATA_WIDTH  8    RAM word width in bits.
//  MEM_DEPTH   256  Number of valid words; must be <= 2**ADDR_WIDTH.
//  AUTO_INC    0    1: WR_DATA post-increments wr_addr and RD_DATA post-increments rd_addr, modulo MEM_DEPTH.
//  PW (localparam) = max(ADDR_WIDTH, DATA_WIDTH). This is the payload width of every frame.
// PORTS
//  clk        in   1           Single clock. All logic is on the rising edge.
//  rst_n      in   1           Asynchronous active-low reset.
//  SS_n       in   1           Slave select, active low. Frames run while SS_n is low.
//  MOSI       in   1           Serial data in, MSB first, sampled on the rising edge of clk.
//  MISO       out  1           Serial data out. Registered; changes only on the rising edge of clk.
//  busy       out  1           High while a frame is in progress (state != IDLE).
//  frame_err  out  1           One-cycle pulse: frame aborted early, or out-of-range access.
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State=IDLE; MISO=0, busy=0, frame_err=0, wr_addr=0, rd_addr=0, bit counter=0.
//   - RAM contents are NOT reset.
//   - Reset in mid-frame aborts the frame with no RAM write and no pointer update.
//  Frame format, MSB first: cmd[1:0], then PW payload bits.
//   - cmd 00 WR_ADDR: payload[ADDR_WIDTH-1:0] is loaded into wr_addr.
//   - cmd 01 WR_DATA: mem[wr_addr] <= payload[DATA_WIDTH-1:0].
//   - cmd 10 RD_ADDR: payload[ADDR_WIDTH-1:0] is loaded into rd_addr.
//   - cmd 11 RD_DATA: payload bits are don't-care. The RAM word is shifted out on MISO.
//  FSM states: IDLE, CMD, PAYLOAD, RD_FETCH, RD_SHIFT, DONE.
//   - IDLE -> CMD: first rising edge with SS_n=0; cmd[1] is sampled on that edge.
//   - CMD -> PAYLOAD (cmd 00/01/10) or RD_FETCH (cmd 11): on the next edge; cmd[0] is sampled.
//   - PAYLOAD: samples PW bits. On the edge that samples the last bit, the register or RAM
//     update takes effect (that same edge), then -> DONE.
//   - RD_FETCH: one edge; the RAM word at rd_addr is registered into the shift register.
//     Word = 0 if rd_addr >= MEM_DEPTH.
//   - RD_SHIFT: on DATA_WIDTH successive edges, MISO <= shreg[DATA_WIDTH-1], shreg <<= 1.
//     MISO therefore shows bit D-1 from the 3rd edge after cmd[1] was sampled. Then -> DONE.
//   - DONE: holds MISO=0 and ignores MOSI until SS_n=1.
//   - Any state, SS_n=1: -> IDLE on that edge, MISO=0.
//  RD_SHIFT latency: the MOSI value during RD_FETCH/RD_SHIFT is ignored.
//  Early SS_n rise (in CMD, PAYLOAD, RD_FETCH or RD_SHIFT before the last bit):
//   - Frame is discarded: no RAM write, no pointer change, no auto-increment.
//   - frame_err pulses in the IDLE-entry cycle.
//  Out-of-range access:
//   - WR_DATA with wr_addr >= MEM_DEPTH: write suppressed, frame_err pulses, no increment.
//   - RD_DATA with rd_addr >= MEM_DEPTH: MISO shifts zeros, frame_err pulses at RD_FETCH, no increment.
//  AUTO_INC=1 increments:
//   - The pointer increments on the completing edge of a valid WR_DATA or RD_DATA
//     (RD_DATA completes on the last RD_SHIFT edge).
//   - MEM_DEPTH-1 wraps to 0.
//  Unused payload MSBs (when PW > field width) are ignored.
//  A new frame requires SS_n=1 for at least one rising edge. Back-to-back frames need no other gap.
//  Read-during-write cannot occur: there is a single frame at a time, so the single RAM port is never contended.
//  busy = (state != IDLE). frame_err is registered and high for exactly one cycle per event.
// TESTING (defaults unless stated)
//  1. WR_ADDR 0xFF, WR_DATA 0x0F, RD_ADDR 0xFF, RD_DATA
//     -> MISO = 0,0,0,0,1,1,1,1 on edges 3..10 after cmd[1]; frame_err stays 0.
//  2. Reset asserted mid-payload of WR_DATA 0xA5 to addr 0x10, then RD addr 0x10
//     -> old content is returned; MISO=0 and busy=0 immediately on rst_n=0.
//  3. SS_n raised after 5 payload bits of WR_ADDR 0x3C
//     -> wr_addr unchanged (0); frame_err one-cycle pulse; next full frame works normally.
//  4. AUTO_INC=1: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF; RD_DATA x2
//     -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); reads return 0x11 then 0x22.
//  5. MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0x55, RD_ADDR 0xF0, RD_DATA
//     -> write suppressed, MISO all zeros, two frame_err pulses.
//  6. ADDR_WIDTH=10, DATA_WIDTH=16, MEM_DEPTH=1024: write 0xBEEF at 0x3FF, read back
//     -> 16-bit MISO stream 0xBEEF, MSB first.

Source files
------------

// File: rtl/spi_slave_ram_param.sv
// SPI slave with an integrated single-port RAM; widths, depth and pointer auto-increment are parameters.
// Frames are cmd[1:0] followed by a max(ADDR_WIDTH, DATA_WIDTH)-bit payload, MSB first, all sampled on clk.
module spi_slave_ram_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(PW + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    RD_FETCH,
    RD_SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-2:0]         payload_q, payload_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  miso_q, miso_d;
  logic                  frame_err_q, frame_err_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  mem_we;
  logic [PW-1:0]         payload_next;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign payload_next = {payload_q, MOSI};
  assign wr_in_range  = ({1'b0, wr_addr_q} < DEPTH_C);
  assign rd_in_range  = ({1'b0, rd_addr_q} < DEPTH_C);
  assign rd_word      = rd_in_range ? mem[rd_addr_q] : '0;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    shreg_d     = shreg_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;

    // Deselect always wins; leaving before DONE means the frame was cut short.
    if (SS_n) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
      if (state_q inside {CMD, PAYLOAD, RD_FETCH, RD_SHIFT}) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_d   = {MOSI, 1'b0};
          cnt_d   = '0;
          miso_d  = 1'b0;
          state_d = CMD;
        end
        CMD: begin
          cmd_d[0] = MOSI;
          cnt_d    = '0;
          state_d  = (cmd_q[1] && MOSI) ? RD_FETCH : PAYLOAD;
        end
        PAYLOAD: begin
          payload_d = payload_next[PW-2:0];
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == CW'(PW - 1)) begin
            state_d = DONE;
            case (cmd_q)
              2'b00: wr_addr_d = payload_next[ADDR_WIDTH-1:0];
              2'b01: begin
                if (wr_in_range) begin
                  mem_we = 1'b1;
                  if (AUTO_INC != 0) wr_addr_d = next_addr(wr_addr_q);
                end else begin
                  frame_err_d = 1'b1;
                end
              end
              2'b10: rd_addr_d = payload_next[ADDR_WIDTH-1:0];
              default: ;
            endcase
          end
        end
        RD_FETCH: begin
          shreg_d     = rd_word;
          frame_err_d = !rd_in_range;
          cnt_d       = '0;
          state_d     = RD_SHIFT;
        end
        RD_SHIFT: begin
          miso_d  = shreg_q[DATA_WIDTH-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = DONE;
            if ((AUTO_INC != 0) && rd_in_range) rd_addr_d = next_addr(rd_addr_q);
          end
        end
        DONE: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      payload_q   <= '0;
      shreg_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      shreg_q     <= shreg_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload_next[DATA_WIDTH-1:0];
  end

  assign MISO      = miso_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

endmodule
